// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: register index and the in-flight record used by the hazard tracker.
package lc3b_types;

  localparam int LC3B_REG_W = 3;

  typedef logic [LC3B_REG_W-1:0] lc3b_reg;

  typedef struct packed {
    logic    valid;
    lc3b_reg dr;
    logic    ld_reg;
    logic    ld_cc;
    logic    is_load;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '0;

endpackage

// File: rtl/lc3b_hazard_match.sv
// Compares one decode source index against every tracked entry; reports a hit, the youngest
// matching entry and whether that youngest producer could be forwarded from.
module lc3b_hazard_match
  import lc3b_types::*;
#(
  parameter int DEPTH   = 3,
  parameter int FWD_MIN = 1
) (
  input  lc3b_reg    src,
  input  logic       needed,
  input  hz_entry_t  ent [DEPTH],
  output logic       hit,
  output logic       fwd_ok,
  output logic [3:0] young
);

  // Scan oldest to youngest so the last assignment wins with the youngest producer.
  always_comb begin
    hit    = 1'b0;
    fwd_ok = 1'b0;
    young  = 4'd0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (needed && ent[e].valid && ent[e].ld_reg && (ent[e].dr == src)) begin
        hit    = 1'b1;
        young  = 4'(e);
        fwd_ok = (e >= FWD_MIN) && !ent[e].is_load;
      end
    end
  end

endmodule

// File: rtl/lc3b_hazard_tracker.sv
// RAW register/CC hazard tracker over DEPTH post-decode stages with flush, hold, occupancy and stall count.
// Optional forwarding is enabled by defining LC3B_HT_FWD_EN.
module lc3b_hazard_tracker
  import lc3b_types::*;
#(
  parameter int DEPTH   = 3,
  parameter int REG_W   = LC3B_REG_W,
  parameter int FLUSH_N = 1,
  parameter int FWD_MIN = 1,
  parameter int SCNT_W  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_sr1,
  input  logic [REG_W-1:0]  id_sr2,
  input  logic              id_sr1_needed,
  input  logic              id_sr2_needed,
  input  logic              id_br_op,
  input  logic [REG_W-1:0]  id_dr,
  input  logic              id_ld_reg,
  input  logic              id_ld_cc,
  input  logic              id_is_load,
  input  logic              advance,
  input  logic              flush,
  input  logic              scnt_clr,
  output logic              dep_stall,
  output logic [DEPTH-1:0]  entry_valid,
  output logic [CNT_W-1:0]  inflight_cnt,
  output logic [SCNT_W-1:0] stall_cycles,
  output logic [3:0]        fwd_sel_a,
  output logic [3:0]        fwd_sel_b
);

  hz_entry_t         ent_q [DEPTH];
  hz_entry_t         ent_d [DEPTH];
  hz_entry_t         rec;
  logic [SCNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       hit_a, hit_b, fwd_ok_a, fwd_ok_b;
  logic [3:0] young_a, young_b;
  logic       haz_a, haz_b, cc_haz, issue;

  lc3b_hazard_match #(.DEPTH(DEPTH), .FWD_MIN(FWD_MIN)) u_match_a (
    .src    (lc3b_reg'(id_sr1)),
    .needed (id_sr1_needed),
    .ent    (ent_q),
    .hit    (hit_a),
    .fwd_ok (fwd_ok_a),
    .young  (young_a)
  );

  lc3b_hazard_match #(.DEPTH(DEPTH), .FWD_MIN(FWD_MIN)) u_match_b (
    .src    (lc3b_reg'(id_sr2)),
    .needed (id_sr2_needed),
    .ent    (ent_q),
    .hit    (hit_b),
    .fwd_ok (fwd_ok_b),
    .young  (young_b)
  );

`ifdef LC3B_HT_FWD_EN
  assign haz_a     = hit_a && !fwd_ok_a;
  assign haz_b     = hit_b && !fwd_ok_b;
  assign fwd_sel_a = (hit_a && fwd_ok_a) ? young_a + 4'd1 : 4'd0;
  assign fwd_sel_b = (hit_b && fwd_ok_b) ? young_b + 4'd1 : 4'd0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ok_a, fwd_ok_b, young_a, young_b};
  assign haz_a      = hit_a;
  assign haz_b      = hit_b;
  assign fwd_sel_a  = 4'd0;
  assign fwd_sel_b  = 4'd0;
`endif

  // CC producers always stall a branch; WB still counts since CC commits on the same edge.
  always_comb begin
    cc_haz = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_q[e].valid && ent_q[e].ld_cc) cc_haz = id_br_op;
    end
  end

  assign dep_stall = id_valid && !flush && (haz_a || haz_b || cc_haz);
  assign issue     = advance && id_valid && !dep_stall && !flush;

  always_comb begin
    rec         = HZ_BUBBLE;
    rec.valid   = 1'b1;
    rec.dr      = lc3b_reg'(id_dr);
    rec.ld_reg  = id_ld_reg;
    rec.ld_cc   = id_ld_cc;
    rec.is_load = id_is_load;
  end

  // Flush kills the records younger than the resolving stage, wherever they land this cycle.
  always_comb begin
    ent_d = ent_q;
    if (advance) begin
      for (int i = 1; i < DEPTH; i++) begin
        ent_d[i] = (flush && (i - 1) < FLUSH_N) ? HZ_BUBBLE : ent_q[i-1];
      end
      ent_d[0] = issue ? rec : HZ_BUBBLE;
    end else if (flush) begin
      for (int i = 0; i < FLUSH_N; i++) ent_d[i] = HZ_BUBBLE;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (scnt_clr) begin
      stall_cycles_d = '0;
    end else if (dep_stall && advance && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= HZ_BUBBLE;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ent_q[i].valid;
      inflight_cnt   = inflight_cnt + CNT_W'(ent_q[i].valid);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_lc3b_hazard_tracker.sv
// Self-checking bench for lc3b_hazard_tracker: directed scenarios plus random traffic against a queue-level model.
module tb_lc3b_hazard_tracker;

  localparam int DEPTH   = 3;
  localparam int FLUSH_N = 1;
  localparam int FWD_MIN = 1;
  localparam int SCNT_W  = 4;
  localparam int SMAX    = (1 << SCNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_sr1_needed, id_sr2_needed, id_br_op;
  logic id_ld_reg, id_ld_cc, id_is_load, advance, flush, scnt_clr;
  logic [2:0] id_sr1, id_sr2, id_dr;
  logic dep_stall;
  logic [DEPTH-1:0] entry_valid;
  logic [1:0] inflight_cnt;
  logic [SCNT_W-1:0] stall_cycles;
  logic [3:0] fwd_sel_a, fwd_sel_b;

  lc3b_hazard_tracker #(
    .DEPTH(DEPTH), .REG_W(3), .FLUSH_N(FLUSH_N), .FWD_MIN(FWD_MIN), .SCNT_W(SCNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_needed(id_sr1_needed), .id_sr2_needed(id_sr2_needed),
    .id_br_op(id_br_op), .id_dr(id_dr),
    .id_ld_reg(id_ld_reg), .id_ld_cc(id_ld_cc), .id_is_load(id_is_load),
    .advance(advance), .flush(flush), .scnt_clr(scnt_clr),
    .dep_stall(dep_stall), .entry_valid(entry_valid), .inflight_cnt(inflight_cnt),
    .stall_cycles(stall_cycles), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit v;
    int dr;
    bit ldr;
    bit ldc;
    bit ld;
  } rec_t;

  rec_t m [DEPTH];
  int   m_scnt;

  // ---------------- reference model ----------------
  function automatic bit m_src_stall(input int src, input bit need);
    if (!need) return 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (m[k].v && m[k].ldr && m[k].dr == src) begin
`ifdef LC3B_HT_FWD_EN
        return !(k >= FWD_MIN && !m[k].ld);
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_src_sel(input int src, input bit need);
`ifdef LC3B_HT_FWD_EN
    if (!need) return 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (m[k].v && m[k].ldr && m[k].dr == src) begin
        if (k >= FWD_MIN && !m[k].ld) return k + 1;
        return 0;
      end
    end
    return 0;
`else
    return (src < 0 && need) ? 1 : 0;
`endif
  endfunction

  function automatic bit m_dep();
    bit cc = 1'b0;
    for (int k = 0; k < DEPTH; k++) if (m[k].v && m[k].ldc) cc = id_br_op;
    return id_valid && !flush &&
           (m_src_stall(int'(id_sr1), id_sr1_needed) || m_src_stall(int'(id_sr2), id_sr2_needed) || cc);
  endfunction

  function automatic logic [DEPTH-1:0] m_valid_bits();
    logic [DEPTH-1:0] b;
    for (int k = 0; k < DEPTH; k++) b[k] = m[k].v;
    return b;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < DEPTH; k++) c += int'(m[k].v);
    return c;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < DEPTH; k++) m[k] = '{default: 0};
    m_scnt = 0;
  endtask

  // One clock: compute the next model state from the current inputs, then cross the edge.
  task automatic tick();
    rec_t n [DEPTH];
    bit   st;
    int   ns;
    st = m_dep();
    n  = m;
    if (advance) begin
      for (int i = DEPTH - 1; i > 0; i--) n[i] = (flush && (i - 1) < FLUSH_N) ? '{default: 0} : m[i-1];
      if (id_valid && !st && !flush)
        n[0] = '{v: 1'b1, dr: int'(id_dr), ldr: id_ld_reg, ldc: id_ld_cc, ld: id_is_load};
      else
        n[0] = '{default: 0};
    end else if (flush) begin
      for (int i = 0; i < FLUSH_N; i++) n[i] = '{default: 0};
    end
    if (scnt_clr) ns = 0;
    else if (st && advance && m_scnt < SMAX) ns = m_scnt + 1;
    else ns = m_scnt;
    @(posedge clk);
    m      = n;
    m_scnt = ns;
    @(negedge clk);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_sr1_needed = 0; id_sr2_needed = 0;
    id_br_op = 0; id_dr = 0; id_ld_reg = 0; id_ld_cc = 0; id_is_load = 0;
    advance = 1; flush = 0; scnt_clr = 0;
  endtask

  task automatic set_op(input int dr, input int s1, input bit n1, input int s2, input bit n2,
                        input bit ldr, input bit ldc, input bit ld, input bit br);
    id_valid = 1; id_dr = 3'(dr); id_sr1 = 3'(s1); id_sr1_needed = n1;
    id_sr2 = 3'(s2); id_sr2_needed = n2; id_ld_reg = ldr; id_ld_cc = ldc;
    id_is_load = ld; id_br_op = br;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_idle();
    reset = 1;
    m_clear();
    @(negedge clk);
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    set_op(2, 0, 1, 7, 1, 1, 1, 0, 1);
    #1;
    checks++; if (entry_valid !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", entry_valid); end
    checks++; if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", inflight_cnt); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_scnt: got %0d want 0", stall_cycles); end
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", dep_stall); end
    checks++; if ({fwd_sel_a, fwd_sel_b} !== 8'h00) begin errors++; $display("FAIL reset_fwd: got %h want 00", {fwd_sel_a, fwd_sel_b}); end
    set_idle();
  endtask

  task automatic test_raw_stall();
    int nst;
    logic [DEPTH-1:0] vexp;
`ifdef LC3B_HT_FWD_EN
    nst = FWD_MIN; vexp = 3'b101;
`else
    nst = DEPTH;   vexp = 3'b001;
`endif
    apply_reset();
    set_op(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    set_op(2, 1, 1, 3, 1, 1, 1, 0, 0);
    for (int c = 0; c <= nst; c++) begin
      #1;
      checks++;
      if (dep_stall !== (c < nst)) begin
        errors++; $display("FAIL raw_stall c%0d: got %b want %b", c, dep_stall, (c < nst));
      end
`ifdef LC3B_HT_FWD_EN
      if (c == nst) begin
        checks++;
        if (fwd_sel_a !== 4'(FWD_MIN + 1)) begin
          errors++; $display("FAIL raw_fwd_sel: got %0d want %0d", fwd_sel_a, FWD_MIN + 1);
        end
      end
`endif
      tick();
    end
    set_idle();
    #1;
    checks++; if (stall_cycles !== 4'(nst)) begin errors++; $display("FAIL raw_scnt: got %0d want %0d", stall_cycles, nst); end
    checks++; if (entry_valid !== vexp) begin errors++; $display("FAIL raw_issue: got %b want %b", entry_valid, vexp); end
  endtask

`ifdef LC3B_HT_FWD_EN
  task automatic test_fwd_load();
    apply_reset();
    set_op(1, 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    set_op(2, 0, 0, 1, 1, 1, 0, 0, 0);
    for (int c = 0; c <= DEPTH; c++) begin
      #1;
      checks++;
      if (dep_stall !== (c < DEPTH)) begin
        errors++; $display("FAIL load_stall c%0d: got %b want %b", c, dep_stall, (c < DEPTH));
      end
      tick();
    end
    set_idle();
  endtask
`endif

  task automatic test_hold();
    apply_reset();
    set_op(5, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_idle();                        tick();
    set_op(4, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(6, 4, 1, 0, 0, 1, 0, 0, 0);
    advance = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (entry_valid !== 3'b101) begin errors++; $display("FAIL hold_valid c%0d: got %b want 101", c, entry_valid); end
      checks++; if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL hold_cnt c%0d: got %0d want 2", c, inflight_cnt); end
      checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL hold_stall c%0d: got %b want 1", c, dep_stall); end
      tick();
    end
    #1;
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL hold_scnt: got %0d want 0", stall_cycles); end
    set_idle();
  endtask

  task automatic test_flush();
    bit want_r2;
`ifdef LC3B_HT_FWD_EN
    want_r2 = 1'b0;
`else
    want_r2 = 1'b1;
`endif
    apply_reset();
    set_op(3, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(2, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(1, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(7, 0, 0, 0, 0, 1, 0, 0, 0);
    flush = 1;
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", dep_stall); end
    tick();
    flush = 0; advance = 0;
    #1;
    checks++; if (entry_valid !== 3'b100) begin errors++; $display("FAIL flush_valid: got %b want 100", entry_valid); end
    checks++; if (inflight_cnt !== 2'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", inflight_cnt); end
    set_op(6, 1, 1, 3, 1, 1, 0, 0, 0);
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL flush_killed: got %b want 0", dep_stall); end
    set_op(6, 2, 1, 0, 0, 1, 0, 0, 0);
    #1;
    checks++; if (dep_stall !== want_r2) begin errors++; $display("FAIL flush_survivor: got %b want %b", dep_stall, want_r2); end
    // flush while held clears entry 0 in place
    apply_reset();
    set_op(2, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(1, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_idle(); advance = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    checks++; if (entry_valid !== 3'b010) begin errors++; $display("FAIL flush_hold_valid: got %b want 010", entry_valid); end
    set_idle();
  endtask

  task automatic test_cc();
    apply_reset();
    set_op(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_idle(); tick(); tick();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL cc_stall: got %b want 1", dep_stall); end
    checks++; if (entry_valid !== 3'b100) begin errors++; $display("FAIL cc_valid: got %b want 100", entry_valid); end
    tick();
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL cc_clear: got %b want 0", dep_stall); end
    tick();
    set_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_op(1, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(2, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(3, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_op(4, 3, 1, 0, 0, 1, 0, 0, 0);
    #1;
    checks++; if (entry_valid !== 3'b111) begin errors++; $display("FAIL mid_pre_valid: got %b want 111", entry_valid); end
    reset = 1;
    #1;
    checks++; if (entry_valid !== 3'b000) begin errors++; $display("FAIL mid_async_valid: got %b want 000", entry_valid); end
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL mid_async_stall: got %b want 0", dep_stall); end
    checks++; if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d want 0", inflight_cnt); end
    m_clear();
    @(negedge clk);
    reset = 0;
    set_idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    set_op(1, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int c = 0; c < 40; c++) tick();
    #1;
    checks++; if (stall_cycles !== 4'(SMAX)) begin errors++; $display("FAIL sat_hold: got %0d want %0d", stall_cycles, SMAX); end
    scnt_clr = 1;
    tick();
    scnt_clr = 0;
    #1;
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL sat_clr: got %0d want 0", stall_cycles); end
    set_idle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_sr1        = 3'($urandom_range(0, 7));
      id_sr2        = 3'($urandom_range(0, 7));
      id_sr1_needed = 1'($urandom_range(0, 1));
      id_sr2_needed = 1'($urandom_range(0, 1));
      id_br_op      = ($urandom_range(0, 3) == 0);
      id_dr         = 3'($urandom_range(0, 7));
      id_ld_reg     = ($urandom_range(0, 3) != 0);
      id_ld_cc      = ($urandom_range(0, 2) == 0);
      id_is_load    = ($urandom_range(0, 3) == 0);
      advance       = ($urandom_range(0, 6) != 0);
      flush         = ($urandom_range(0, 9) == 0);
      scnt_clr      = ($urandom_range(0, 39) == 0);
      #1;
      checks++; if (dep_stall !== m_dep()) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, dep_stall, m_dep()); end
      checks++; if (entry_valid !== m_valid_bits()) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, entry_valid, m_valid_bits()); end
      checks++; if (inflight_cnt !== 2'(m_count())) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, inflight_cnt, m_count()); end
      checks++; if (stall_cycles !== 4'(m_scnt)) begin errors++; $display("FAIL rnd_scnt c%0d: got %0d want %0d", c, stall_cycles, m_scnt); end
      checks++;
      if (fwd_sel_a !== 4'(m_src_sel(int'(id_sr1), id_sr1_needed)) || fwd_sel_b !== 4'(m_src_sel(int'(id_sr2), id_sr2_needed))) begin
        errors++;
        $display("FAIL rnd_fwd c%0d: got %0d/%0d want %0d/%0d", c, fwd_sel_a, fwd_sel_b,
                 m_src_sel(int'(id_sr1), id_sr1_needed), m_src_sel(int'(id_sr2), id_sr2_needed));
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    reset = 1;
    set_idle();
    m_clear();
    test_reset();
    test_raw_stall();
`ifdef LC3B_HT_FWD_EN
    test_fwd_load();
`endif
    test_hold();
    test_flush();
    test_cc();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
